// File: rtl/seg7_pkg.sv
// Shared types, pin constants and the hex-to-segment table for the 7-segment display path.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low segments, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] hex_to_seg(input digit_t d);
    logic [6:0] s;
    s = SEG_BLANK;
    case (d)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low segment decoder, also used by the decode stage.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  digit_t      digit_i,
  output logic [6:0]  seg_o
);

  assign seg_o = hex_to_seg(digit_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous double buffering.
// Optional decimal points are built when SEG7_DP_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 100_000,
  parameter int unsigned BLANK_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_i,
  input  logic [3:0]  en_mask_i,
  input  logic        load_i,
  output logic        pending_o,
  output logic        frame_o,
  output logic [3:0]  AN,
  output logic [6:0]  SEG
`ifdef SEG7_DP_EN
  ,
  input  logic [3:0]  dp_i,
  output logic        DP
`endif
);

  localparam int unsigned TickW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(DIGIT_TICKS - 1);
  localparam logic [TickW-1:0] BlankEnd = TickW'(BLANK_TICKS);

  logic [TickW-1:0] tick_q, tick_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      pend_digits_q, pend_digits_d, act_digits_q, act_digits_d;
  logic [3:0]       pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic             pending_q, pending_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             wrap, lit;
  digit_t           act_digit;
  logic [6:0]       dec_seg;

  assign wrap      = (tick_q == TickLast) && (idx_q == 2'd3);
  assign lit       = (tick_q >= BlankEnd) && act_en_q[idx_q];
  assign act_digit = act_digits_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .digit_i (act_digit),
    .seg_o   (dec_seg)
  );

`ifdef SEG7_DP_EN
  logic [3:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic       dp_q, dp_d;
`endif

  always_comb begin
    tick_d        = tick_q + 1'b1;
    idx_d         = idx_q;
    pend_digits_d = pend_digits_q;
    pend_en_d     = pend_en_q;
    act_digits_d  = act_digits_q;
    act_en_d      = act_en_q;
    pending_d     = pending_q;
    an_d          = AN_OFF;
    seg_d         = SEG_BLANK;
`ifdef SEG7_DP_EN
    pend_dp_d     = pend_dp_q;
    act_dp_d      = act_dp_q;
    dp_d          = 1'b1;
`endif

    if (tick_q == TickLast) begin
      tick_d = '0;
      idx_d  = idx_q + 2'd1;
    end

    // Apply before capture so a load on the wrap cycle stays pending for a full frame.
    if (wrap && pending_q) begin
      act_digits_d = pend_digits_q;
      act_en_d     = pend_en_q;
      pending_d    = 1'b0;
`ifdef SEG7_DP_EN
      act_dp_d     = pend_dp_q;
`endif
    end

    if (load_i) begin
      pend_digits_d = digits_i;
      pend_en_d     = en_mask_i;
      pending_d     = 1'b1;
`ifdef SEG7_DP_EN
      pend_dp_d     = dp_i;
`endif
    end

    if (lit) begin
      an_d  = ~(4'b1000 >> idx_q);
      seg_d = dec_seg;
`ifdef SEG7_DP_EN
      dp_d  = ~act_dp_q[idx_q];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q        <= '0;
      idx_q         <= '0;
      pend_digits_q <= '0;
      pend_en_q     <= '0;
      act_digits_q  <= '0;
      act_en_q      <= '0;
      pending_q     <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
    end else begin
      tick_q        <= tick_d;
      idx_q         <= idx_d;
      pend_digits_q <= pend_digits_d;
      pend_en_q     <= pend_en_d;
      act_digits_q  <= act_digits_d;
      act_en_q      <= act_en_d;
      pending_q     <= pending_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

`ifdef SEG7_DP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_dp_q <= '0;
      act_dp_q  <= '0;
      dp_q      <= 1'b1;
    end else begin
      pend_dp_q <= pend_dp_d;
      act_dp_q  <= act_dp_d;
      dp_q      <= dp_d;
    end
  end

  assign DP = dp_q;
`endif

  assign pending_o = pending_q;
  assign frame_o   = wrap;
  assign AN        = an_q;
  assign SEG       = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with DIGIT_TICKS=8, BLANK_TICKS=2.
module tb_seg7_scan_driver;

  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_i = '0;
  logic [3:0]  en_mask_i = '0;
  logic        load_i = 1'b0;
  logic        pending_o, frame_o;
  logic [3:0]  AN;
  logic [6:0]  SEG;
`ifdef SEG7_DP_EN
  logic [3:0]  dp_i = '0;
  logic        DP;
`endif

  int nvec = 0;
  int nfail = 0;

  exp_t sb_q[$];

  // Reference model state
  int          m_tick = 0;
  logic [1:0]  m_idx = '0;
  logic [15:0] m_pend_dig = '0, m_act_dig = '0;
  logic [3:0]  m_pend_en = '0, m_act_en = '0;
  logic        m_pending = 1'b0;

  int          lit_cnt [4];
  logic [6:0]  lit_seg [4];

  seg7_scan_driver #(
    .DIGIT_TICKS (8),
    .BLANK_TICKS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_i  (digits_i),
    .en_mask_i (en_mask_i),
    .load_i    (load_i),
    .pending_o (pending_o),
    .frame_o   (frame_o),
    .AN        (AN),
    .SEG       (SEG)
`ifdef SEG7_DP_EN
    ,
    .dp_i      (dp_i),
    .DP        (DP)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: one expected pin state per clock edge driven by cycle().
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      nvec++;
      if (AN !== e.an || SEG !== e.seg) begin
        nfail++;
        $display("FAIL scoreboard t=%0t AN=%b SEG=%b expected AN=%b SEG=%b",
                 $time, AN, SEG, e.an, e.seg);
      end
    end
  end

  // Push the pins expected after the coming edge, advance the model, take the edge.
  task automatic cycle();
    exp_t e;
    logic wrap;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    if (!rst && m_tick >= 2 && m_act_en[m_idx]) begin
      e.an[2'd3 - m_idx] = 1'b0;
      e.seg = HEX[m_act_dig[4*m_idx +: 4]];
    end
    sb_q.push_back(e);
    if (rst) begin
      m_tick = 0; m_idx = '0; m_pending = 1'b0;
      m_pend_dig = '0; m_pend_en = '0; m_act_dig = '0; m_act_en = '0;
    end else begin
      wrap = (m_tick == 7) && (m_idx == 2'd3);
      if (wrap && m_pending) begin
        m_act_dig = m_pend_dig; m_act_en = m_pend_en; m_pending = 1'b0;
      end
      if (load_i) begin
        m_pend_dig = digits_i; m_pend_en = en_mask_i; m_pending = 1'b1;
      end
      if (m_tick == 7) begin
        m_tick = 0; m_idx = m_idx + 2'd1;
      end else begin
        m_tick++;
      end
    end
    @(posedge clk);
    #3;
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] en);
    digits_i = d; en_mask_i = en; load_i = 1'b1;
    cycle();
    load_i = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_o !== 1'b1 && n < 64) begin
      cycle();
      n++;
    end
    if (frame_o !== 1'b1) begin
      nvec++; nfail++;
      $display("FAIL wait_frame frame_o=%b after %0d cycles, required 1", frame_o, n);
    end
  endtask

  // Call right after the wrap edge: records lit cycles and segments per slot for one frame.
  task automatic scan_frame();
    for (int k = 0; k < 4; k++) begin lit_cnt[k] = 0; lit_seg[k] = 'x; end
    repeat (32) begin
      cycle();
      for (int k = 0; k < 4; k++) begin
        if (AN == ~(4'b1000 >> k)) begin
          lit_cnt[k]++;
          lit_seg[k] = SEG;
        end
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) begin
      cycle();
      nvec++;
      if (AN !== 4'hF || SEG !== 7'h7F || pending_o !== 1'b0) begin
        nfail++;
        $display("FAIL reset_state AN=%b SEG=%b pending_o=%b required 1111/1111111/0",
                 AN, SEG, pending_o);
      end
    end
    rst = 1'b0;
    n = 1;
    while (frame_o !== 1'b1 && n < 64) begin
      cycle();
      n++;
    end
    nvec++;
    if (n != 32 || frame_o !== 1'b1) begin
      nfail++;
      $display("FAIL first_frame at cycle %0d frame_o=%b, required cycle 32", n, frame_o);
    end
  endtask

  task automatic test_full_en();
    logic [6:0] want [4];
    int n = 0;
    want = '{7'b0000110, 7'b0100000, 7'b0000000, 7'b0000100};
    cycle();
    load(16'h9863, 4'hF);
    nvec++;
    if (pending_o !== 1'b1) begin
      nfail++;
      $display("FAIL pending_after_load pending_o=%b required 1", pending_o);
    end
    while (frame_o !== 1'b1 && n < 64) begin
      cycle();
      n++;
      nvec++;
      if (pending_o !== 1'b1) begin
        nfail++;
        $display("FAIL pending_hold pending_o=%b required 1", pending_o);
      end
    end
    cycle();
    nvec++;
    if (pending_o !== 1'b0) begin
      nfail++;
      $display("FAIL pending_clear pending_o=%b required 0", pending_o);
    end
    scan_frame();
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (lit_cnt[k] != 6 || lit_seg[k] !== want[k]) begin
        nfail++;
        $display("FAIL full_en slot %0d lit=%0d SEG=%b required 6/%b",
                 k, lit_cnt[k], lit_seg[k], want[k]);
      end
    end
  endtask

  task automatic test_en_mask();
    int want [4];
    want = '{6, 0, 6, 0};
    load(16'h9863, 4'b0101);
    wait_frame();
    cycle();
    scan_frame();
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (lit_cnt[k] != want[k]) begin
        nfail++;
        $display("FAIL en_mask slot %0d lit=%0d required %0d", k, lit_cnt[k], want[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    load(16'h1111, 4'hF);
    cycle();
    load(16'h2222, 4'hF);
    wait_frame();
    cycle();
    scan_frame();
    nvec++;
    if (lit_seg[0] !== 7'b0010010 || lit_seg[3] !== 7'b0010010 || lit_cnt[0] != 6) begin
      nfail++;
      $display("FAIL last_wins SEG0=%b SEG3=%b lit=%0d required 0010010/0010010/6",
               lit_seg[0], lit_seg[3], lit_cnt[0]);
    end
    // Load landing on the wrap cycle itself.
    load(16'h4444, 4'hF);
    wait_frame();
    load(16'h5555, 4'hF);
    nvec++;
    if (pending_o !== 1'b1) begin
      nfail++;
      $display("FAIL load_on_wrap pending_o=%b required 1", pending_o);
    end
    scan_frame();
    nvec++;
    if (lit_seg[0] !== 7'b1001100) begin
      nfail++;
      $display("FAIL load_on_wrap_old SEG=%b required 1001100", lit_seg[0]);
    end
    wait_frame();
    cycle();
    scan_frame();
    nvec++;
    if (lit_seg[0] !== 7'b0100100 || pending_o !== 1'b0) begin
      nfail++;
      $display("FAIL load_on_wrap_new SEG=%b pending_o=%b required 0100100/0",
               lit_seg[0], pending_o);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    wait_frame();
    cycle();
    repeat (3) cycle();
    load(16'hABCD, 4'hF);
    repeat (8) cycle();
    nvec++;
    if (pending_o !== 1'b1) begin
      nfail++;
      $display("FAIL mid_reset_pre pending_o=%b required 1", pending_o);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    nvec++;
    if (AN !== 4'hF || pending_o !== 1'b0) begin
      nfail++;
      $display("FAIL mid_reset AN=%b pending_o=%b required 1111/0", AN, pending_o);
    end
    n = 1;
    while (frame_o !== 1'b1 && n < 64) begin
      cycle();
      n++;
    end
    nvec++;
    if (n != 32) begin
      nfail++;
      $display("FAIL mid_reset_restart frame at cycle %0d required 32", n);
    end
  endtask

  task automatic test_random();
    logic found;
    for (int c = 0; c < 200 * 32; c++) begin
      load_i    = ($urandom_range(0, 15) == 0);
      digits_i  = 16'($urandom);
      en_mask_i = 4'($urandom);
      cycle();
      nvec++;
      if (!$onehot0(~AN)) begin
        nfail++;
        $display("FAIL random_onehot AN=%b required at most one 0", AN);
      end
      if (AN != 4'hF) begin
        found = 1'b0;
        for (int k = 0; k < 16; k++) if (SEG == HEX[k]) found = 1'b1;
        nvec++;
        if (!found) begin
          nfail++;
          $display("FAIL random_seg SEG=%b required a hex table entry", SEG);
        end
      end
    end
    load_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_en();
    test_en_mask();
    test_back_to_back();
    test_mid_reset();
    test_random();
    cycle();
    #10;
    nvec++;
    if (sb_q.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_drain left=%0d required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
